// File: rtl/data_mem_responder.sv
// Data memory responder: a request/response port in front of a byte-enabled
// word array. Accesses that span two words take an extra cycle (ACC1).
//
// state | meaning
// IDLE  | ready for a request; read of the addressed word launched
// ACC0  | first word: store bytes commit, load data captured
// ACC1  | second word (index+1, wrapping) for word-crossing accesses
// RESP  | response held until resp_ready
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 17,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_dtype,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t state, state_nxt;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            dtype_q;
    logic                  unsigned_q;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_q;
    logic [31:0] word0_q;
    logic [IDX_W-1:0] rd_idx;

    logic             accept;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             misaligned;
    logic [7:0]       be;
    logic [63:0]      wlanes;
    logic [63:0]      span;
    logic [31:0]      load_val;
    logic             unused_addr_bits;

    assign accept     = req_valid && (state == IDLE);
    assign off        = addr_q[1:0];
    assign idx        = addr_q[IDX_W+1:2];
    assign idx_nxt    = idx + 1'b1;
    assign misaligned = ((dtype_q == 2'b01) && (off == 2'd3)) ||
                        ((dtype_q == 2'b10) && (off != 2'd0));
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign unused_addr_bits = ^addr_q[ADDR_WIDTH-1:IDX_W+2];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = (req_dtype == 2'b11) ? RESP : ACC0;
            ACC0: state_nxt = misaligned ? ACC1 : RESP;
            ACC1: state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Byte lanes across the two-word span, plus load extraction and extension
    always_comb begin
        be = 8'h00;
        case (dtype_q)
            2'b00:   be = 8'b0000_0001 << off;
            2'b01:   be = 8'b0000_0011 << off;
            2'b10:   be = 8'b0000_1111 << off;
            default: be = 8'h00;
        endcase
        wlanes = {32'h0, wdata_q} << {off, 3'b000};
        if (state == ACC1) span = {rd_q, word0_q} >> {off, 3'b000};
        else               span = {32'h0, rd_q} >> {off, 3'b000};
        load_val = span[31:0];
        case (dtype_q)
            2'b00:   load_val = unsigned_q ? {24'h0, span[7:0]}  : {{24{span[7]}}, span[7:0]};
            2'b01:   load_val = unsigned_q ? {16'h0, span[15:0]} : {{16{span[15]}}, span[15:0]};
            default: load_val = span[31:0];
        endcase
    end

    // Read address: the requested word while idle so data is ready in ACC0,
    // then the following word for the second half of a crossing access
    always_comb begin
        rd_idx = (state == IDLE) ? req_addr[IDX_W+1:2] : idx_nxt;
    end

    // Storage: per-byte writes, synchronous read; never reset
    always_ff @(posedge clk) begin
        if (state == ACC0 && we_q) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
        end
        if (state == ACC1 && we_q) begin
            for (int b = 0; b < 4; b++)
                if (be[4+b]) mem[idx_nxt][8*b +: 8] <= wlanes[32+8*b +: 8];
        end
        rd_q <= mem[rd_idx];
    end

    // Request latch and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dtype_q    <= 2'b00;
            unsigned_q <= 1'b0;
            word0_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                dtype_q    <= req_dtype;
                unsigned_q <= req_unsigned;
            end
            case (state)
                IDLE: begin
                    if (req_valid && req_dtype == 2'b11) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                ACC0: begin
                    word0_q <= rd_q;
                    if (!misaligned) begin
                        resp_err   <= 1'b0;
                        resp_rdata <= we_q ? '0 : load_val;
                    end
                end
                ACC1: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= we_q ? '0 : load_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-array reference model feeding a queue of
// expected responses, checked as each response appears.
module tb_data_mem_responder;
    localparam int DEPTH     = 1024;
    localparam int MEM_BYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [16:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_dtype;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [MEM_BYTES];
    int         vectors = 0;
    int         miscompares = 0;

    data_mem_responder #(.ADDR_WIDTH(17), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_dtype(req_dtype),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // One full transaction: model update, drive, wait, pop and compare,
    // optionally stall resp_ready for 'hold' cycles before the handshake.
    task automatic xact(input logic we, input logic [16:0] addr, input logic [31:0] wd,
                        input logic [1:0] dt, input logic uns, input int hold);
        exp_t        e;
        int          n;
        int          lat;
        logic [31:0] v;
        logic [1:0]  o;
        o       = addr[1:0];
        e.err   = (dt == 2'b11);
        e.rdata = 32'h0;
        if (e.err) e.lat = 1;
        else if ((dt == 2'b01 && o == 2'd3) || (dt == 2'b10 && o != 2'd0)) e.lat = 3;
        else e.lat = 2;
        if (!e.err) begin
            n = 1 << dt;
            if (we) begin
                for (int i = 0; i < n; i++) model[(int'(addr) + i) % MEM_BYTES] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = model[(int'(addr) + i) % MEM_BYTES];
                if (!uns && n < 4 && v[8*n-1])
                    for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
                e.rdata = v;
            end
        end
        sb.push_back(e);

        req_we = we; req_addr = addr; req_wdata = wd; req_dtype = dt; req_unsigned = uns;
        req_valid = 1'b1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_idle addr=%h got=%b want=1", addr, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        vectors++;
        if (lat !== e.lat) begin
            miscompares++;
            $display("FAIL latency addr=%h got=%0d want=%0d", addr, lat, e.lat);
        end
        vectors++;
        if (resp_rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL rdata addr=%h dt=%b got=%h want=%h", addr, dt, resp_rdata, e.rdata);
        end
        vectors++;
        if (resp_err !== e.err) begin
            miscompares++;
            $display("FAIL err addr=%h got=%b want=%b", addr, resp_err, e.err);
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold cycle=%0d got valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0",
                         k, resp_valid, resp_rdata, resp_err, req_ready, e.rdata, e.err);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL handshake_idle got valid=%b ready=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_dtype = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        xact(1'b1, 17'h100, 32'hDEADBEEF, 2'b10, 1'b0, 0);
        xact(1'b0, 17'h100, 32'h0, 2'b10, 1'b0, 0);
    endtask

    task automatic test_subword();
        xact(1'b0, 17'h103, 32'h0, 2'b00, 1'b0, 0);
        xact(1'b0, 17'h103, 32'h0, 2'b00, 1'b1, 0);
        xact(1'b0, 17'h102, 32'h0, 2'b01, 1'b0, 0);
        xact(1'b0, 17'h100, 32'h0, 2'b01, 1'b1, 0);
        xact(1'b0, 17'h101, 32'h0, 2'b01, 1'b0, 0);
    endtask

    task automatic test_misaligned();
        for (int a = 'h200; a < 'h208; a++) xact(1'b1, 17'(a), 32'h0, 2'b00, 1'b0, 0);
        xact(1'b1, 17'h201, 32'h11223344, 2'b10, 1'b0, 0);
        xact(1'b0, 17'h201, 32'h0, 2'b10, 1'b0, 0);
        xact(1'b0, 17'h200, 32'h0, 2'b00, 1'b1, 0);
        for (int a = 'h205; a < 'h208; a++) xact(1'b0, 17'(a), 32'h0, 2'b00, 1'b1, 0);
        xact(1'b0, 17'h203, 32'h0, 2'b01, 1'b0, 0);
    endtask

    task automatic test_wrap();
        xact(1'b1, 17'(MEM_BYTES - 2), 32'hA1B2C3D4, 2'b10, 1'b0, 0);
        xact(1'b0, 17'h000, 32'h0, 2'b01, 1'b1, 0);
        xact(1'b0, 17'(MEM_BYTES - 2), 32'h0, 2'b10, 1'b0, 0);
    endtask

    task automatic test_error();
        xact(1'b1, 17'h100, 32'h12345678, 2'b11, 1'b0, 5);
        xact(1'b0, 17'h100, 32'h0, 2'b10, 1'b0, 0);
    endtask

    task automatic test_reset_in_acc1();
        xact(1'b1, 17'h300, 32'h0, 2'b10, 1'b0, 0);
        xact(1'b1, 17'h304, 32'h0, 2'b10, 1'b0, 0);
        req_we = 1'b1; req_addr = 17'h301; req_wdata = 32'hAABBCCDD;
        req_dtype = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_acc1 got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        model['h301] = 8'hDD; model['h302] = 8'hCC; model['h303] = 8'hBB;
        req_we = 1'b0; req_addr = 17'h300; req_dtype = 2'b10; req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ignore got ready=%b valid=%b want 1/0", req_ready, resp_valid);
        end
        rst_n = 1'b1;
        xact(1'b0, 17'h300, 32'h0, 2'b10, 1'b0, 0);
        xact(1'b0, 17'h304, 32'h0, 2'b10, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_misaligned();
        test_wrap();
        test_error();
        test_reset_in_acc1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
